// File: rtl/trap_controller.sv
// Trap controller: arbitrates exceptions, interrupts and mret, offers the trap record to the CSR
// unit over valid/ack, then flushes, redirects the PC and masks requests for a drain window.
module trap_controller #(
  parameter int XLEN         = 32,
  parameter int NUM_SRC      = 4,
  parameter int NUM_IRQ      = 3,
  parameter int CAUSE_W      = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         exc_req,
  input  logic [NUM_SRC*CAUSE_W-1:0] exc_cause,
  input  logic [NUM_SRC*XLEN-1:0]    exc_pc,
  input  logic [NUM_SRC*XLEN-1:0]    exc_tval,
  input  logic [NUM_IRQ-1:0]         irq_pending,
  input  logic                       irq_enable,
  input  logic                       wb_valid,
  input  logic [XLEN-1:0]            wb_pc,
  input  logic                       mret_req,
  input  logic [XLEN-1:0]            mepc_in,
  input  logic [XLEN-1:0]            trap_vector,
  input  logic                       csr_ack,
  output logic                       trap_valid,
  output logic                       trap_is_irq,
  output logic [CAUSE_W-1:0]         trap_cause,
  output logic [XLEN-1:0]            trap_pc,
  output logic [XLEN-1:0]            trap_tval,
  output logic                       flush,
  output logic                       redirect_valid,
  output logic [XLEN-1:0]            redirect_pc,
  output logic                       busy
);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_REDIRECT, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [3:0]           drain_cnt_q, drain_cnt_d;
  logic                 trap_valid_q, trap_valid_d;
  logic                 trap_is_irq_q, trap_is_irq_d;
  logic [CAUSE_W-1:0]   trap_cause_q, trap_cause_d;
  logic [XLEN-1:0]      trap_pc_q, trap_pc_d;
  logic [XLEN-1:0]      trap_tval_q, trap_tval_d;
  logic                 flush_q, flush_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d;
  logic                 busy_q, busy_d;

  logic                 exc_hit, irq_hit;
  logic [CAUSE_W-1:0]   arb_cause;
  logic [XLEN-1:0]      arb_pc, arb_tval;

  // Loops run high-to-low so the lowest index is the last (winning) assignment.
  always_comb begin
    exc_hit   = 1'b0;
    irq_hit   = 1'b0;
    arb_cause = '0;
    arb_pc    = '0;
    arb_tval  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (exc_req[i]) begin
        exc_hit   = 1'b1;
        arb_cause = exc_cause[i*CAUSE_W +: CAUSE_W];
        arb_pc    = exc_pc[i*XLEN +: XLEN];
        arb_tval  = exc_tval[i*XLEN +: XLEN];
      end
    end
    if (!exc_hit && irq_enable && wb_valid) begin
      for (int j = NUM_IRQ - 1; j >= 0; j--) begin
        if (irq_pending[j]) begin
          irq_hit   = 1'b1;
          arb_cause = CAUSE_W'(j);
          arb_pc    = wb_pc;
          arb_tval  = '0;
        end
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    drain_cnt_d      = drain_cnt_q;
    trap_valid_d     = trap_valid_q;
    trap_is_irq_d    = trap_is_irq_q;
    trap_cause_d     = trap_cause_q;
    trap_pc_d        = trap_pc_q;
    trap_tval_d      = trap_tval_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      S_IDLE: begin
        if (exc_hit || irq_hit) begin
          state_d       = S_OFFER;
          trap_valid_d  = 1'b1;
          trap_is_irq_d = irq_hit;
          trap_cause_d  = arb_cause;
          trap_pc_d     = arb_pc;
          trap_tval_d   = arb_tval;
        end else if (mret_req) begin
          state_d          = S_REDIRECT;
          trap_is_irq_d    = 1'b0;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = mepc_in;
          drain_cnt_d      = 4'(DRAIN_CYCLES);
        end
      end
      S_OFFER: begin
        if (csr_ack) begin
          state_d          = S_REDIRECT;
          trap_valid_d     = 1'b0;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = trap_vector;
          drain_cnt_d      = 4'(DRAIN_CYCLES);
        end
      end
      // The redirect cycle is the first masked cycle of the drain window.
      S_REDIRECT, S_DRAIN: begin
        drain_cnt_d = drain_cnt_q - 4'd1;
        state_d     = (drain_cnt_q <= 4'd1) ? S_IDLE : S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      drain_cnt_q      <= '0;
      trap_valid_q     <= 1'b0;
      trap_is_irq_q    <= 1'b0;
      trap_cause_q     <= '0;
      trap_pc_q        <= '0;
      trap_tval_q      <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      drain_cnt_q      <= drain_cnt_d;
      trap_valid_q     <= trap_valid_d;
      trap_is_irq_q    <= trap_is_irq_d;
      trap_cause_q     <= trap_cause_d;
      trap_pc_q        <= trap_pc_d;
      trap_tval_q      <= trap_tval_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  assign trap_valid     = trap_valid_q;
  assign trap_is_irq    = trap_is_irq_q;
  assign trap_cause     = trap_cause_q;
  assign trap_pc        = trap_pc_q;
  assign trap_tval      = trap_tval_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed vectors, a timeline model checked every cycle, and literal checks.
module tb_trap_controller;
  localparam int XLEN = 32, NUM_SRC = 4, NUM_IRQ = 3, CAUSE_W = 4, DRAIN = 2;

  logic                       clk, rst;
  logic [NUM_SRC-1:0]         exc_req;
  logic [NUM_SRC*CAUSE_W-1:0] exc_cause;
  logic [NUM_SRC*XLEN-1:0]    exc_pc, exc_tval;
  logic [NUM_IRQ-1:0]         irq_pending;
  logic                       irq_enable, wb_valid, mret_req, csr_ack;
  logic [XLEN-1:0]            wb_pc, mepc_in, trap_vector;
  logic                       trap_valid, trap_is_irq, flush, redirect_valid, busy;
  logic [CAUSE_W-1:0]         trap_cause;
  logic [XLEN-1:0]            trap_pc, trap_tval, redirect_pc;

  trap_controller #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_IRQ(NUM_IRQ), .CAUSE_W(CAUSE_W),
                    .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .irq_pending(irq_pending), .irq_enable(irq_enable),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .mret_req(mret_req), .mepc_in(mepc_in),
    .trap_vector(trap_vector), .csr_ack(csr_ack), .trap_valid(trap_valid),
    .trap_is_irq(trap_is_irq), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a pending offer plus the cycle at which arbitration is next allowed.
  bit               e_tv, e_irq, e_flush, e_rv, e_busy;
  logic [CAUSE_W-1:0] e_cause;
  logic [XLEN-1:0]  e_pc, e_tval, e_rpc;
  int               free_at = 0;

  always @(posedge clk) begin
    int t;
    bit found;
    t = cyc;
    cyc = cyc + 1;
    e_flush = 0;
    e_rv = 0;
    if (rst) begin
      e_tv = 0; e_irq = 0; e_cause = '0; e_pc = '0; e_tval = '0; e_rpc = '0;
      free_at = t + 1;
    end else if (e_tv) begin
      if (csr_ack) begin
        e_tv = 0; e_flush = 1; e_rv = 1; e_rpc = trap_vector;
        free_at = t + 1 + DRAIN;
      end
    end else if (t >= free_at) begin
      found = 0;
      for (int i = 0; i < NUM_SRC; i++)
        if (!found && exc_req[i]) begin
          found = 1; e_tv = 1; e_irq = 0;
          e_cause = exc_cause[i*CAUSE_W +: CAUSE_W];
          e_pc = exc_pc[i*XLEN +: XLEN];
          e_tval = exc_tval[i*XLEN +: XLEN];
        end
      if (irq_enable && wb_valid)
        for (int j = 0; j < NUM_IRQ; j++)
          if (!found && irq_pending[j]) begin
            found = 1; e_tv = 1; e_irq = 1;
            e_cause = CAUSE_W'(j); e_pc = wb_pc; e_tval = '0;
          end
      if (found) free_at = 32'h7fff_ffff;
      else if (mret_req) begin
        e_irq = 0; e_flush = 1; e_rv = 1; e_rpc = mepc_in;
        free_at = t + 1 + DRAIN;
      end
    end
    e_busy = e_tv || (cyc < free_at);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_trap_valid", 64'(trap_valid), 64'(e_tv));
      check("m_trap_is_irq", 64'(trap_is_irq), 64'(e_irq));
      check("m_trap_cause", 64'(trap_cause), 64'(e_cause));
      check("m_trap_pc", 64'(trap_pc), 64'(e_pc));
      check("m_trap_tval", 64'(trap_tval), 64'(e_tval));
      check("m_flush", 64'(flush), 64'(e_flush));
      check("m_redirect_valid", 64'(redirect_valid), 64'(e_rv));
      check("m_redirect_pc", 64'(redirect_pc), 64'(e_rpc));
      check("m_busy", 64'(busy), 64'(e_busy));
    end
  end

  task automatic ack_and_drain();
    csr_ack = 1;
    @(negedge clk);
    csr_ack = 0;
    repeat (DRAIN) @(negedge clk);
  endtask

  initial begin
    int r_cyc, tv_cyc;
    bit seen;
    rst = 1; exc_req = '0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    irq_pending = '0; irq_enable = 0; wb_valid = 0; wb_pc = '0; mret_req = 0;
    mepc_in = '0; trap_vector = '0; csr_ack = 0;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    rst = 0;
    check("rst_trap_valid", 64'(trap_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);

    // Single exception from source 2, acked on the second offer cycle
    exc_req = 4'b0100;
    exc_cause[2*CAUSE_W +: CAUSE_W] = 4'd2;
    exc_pc[2*XLEN +: XLEN] = 32'h8000_0010;
    exc_tval[2*XLEN +: XLEN] = 32'h0000_FFFF;
    trap_vector = 32'h8000_0100;
    @(negedge clk);
    exc_req = '0;
    check("exc_valid", 64'(trap_valid), 64'd1);
    check("exc_cause", 64'(trap_cause), 64'd2);
    check("exc_pc", 64'(trap_pc), 64'h8000_0010);
    check("exc_tval", 64'(trap_tval), 64'h0000_FFFF);
    @(negedge clk);
    check("exc_valid_held", 64'(trap_valid), 64'd1);
    csr_ack = 1;
    @(negedge clk);
    csr_ack = 0;
    check("exc_redirect", 64'({flush, redirect_valid, trap_valid}), 64'b110);
    check("exc_redirect_pc", 64'(redirect_pc), 64'h8000_0100);
    @(negedge clk);
    check("exc_drain_busy", 64'({busy, flush}), 64'b10);
    @(negedge clk);
    check("exc_idle_busy", 64'(busy), 64'd0);

    // Priority: exception source 1 beats source 3, irq and mret
    exc_req = 4'b1010;
    exc_cause[1*CAUSE_W +: CAUSE_W] = 4'd5;
    exc_pc[1*XLEN +: XLEN] = 32'h8000_0020;
    exc_tval[1*XLEN +: XLEN] = 32'h11;
    exc_cause[3*CAUSE_W +: CAUSE_W] = 4'd7;
    exc_pc[3*XLEN +: XLEN] = 32'h8000_0030;
    irq_pending = 3'b001; irq_enable = 1; wb_valid = 1; mret_req = 1;
    @(negedge clk);
    exc_req = '0; irq_pending = '0; mret_req = 0;
    check("prio_cause", 64'(trap_cause), 64'd5);
    check("prio_pc", 64'(trap_pc), 64'h8000_0020);
    check("prio_is_irq", 64'(trap_is_irq), 64'd0);
    ack_and_drain();

    // Interrupt: line 1 wins over line 2
    irq_pending = 3'b110; irq_enable = 1; wb_valid = 1; wb_pc = 32'h8000_0040;
    @(negedge clk);
    irq_pending = '0;
    check("irq_is_irq", 64'(trap_is_irq), 64'd1);
    check("irq_cause", 64'(trap_cause), 64'd1);
    check("irq_pc", 64'(trap_pc), 64'h8000_0040);
    check("irq_tval", 64'(trap_tval), 64'd0);
    ack_and_drain();
    irq_pending = 3'b110; irq_enable = 0; wb_valid = 1;
    repeat (3) @(negedge clk);
    check("irq_disabled", 64'({trap_valid, busy}), 64'd0);
    irq_enable = 1; wb_valid = 0;
    repeat (3) @(negedge clk);
    check("irq_no_wb", 64'({trap_valid, busy}), 64'd0);
    irq_pending = '0;

    // mret
    mret_req = 1; mepc_in = 32'h8000_0044;
    @(negedge clk);
    mret_req = 0;
    check("mret_redirect", 64'({flush, redirect_valid, trap_valid}), 64'b110);
    check("mret_pc", 64'(redirect_pc), 64'h8000_0044);
    check("mret_is_irq", 64'(trap_is_irq), 64'd0);
    repeat (DRAIN) @(negedge clk);

    // Masking with a held request and a stray ack in the drain window
    exc_req = 4'b0001;
    exc_cause[0 +: CAUSE_W] = 4'd3;
    exc_pc[0 +: XLEN] = 32'h8000_0000;
    @(negedge clk);
    check("mask_first_cause", 64'({trap_valid, trap_cause}), 64'h13);
    csr_ack = 1;
    @(negedge clk);
    csr_ack = 0;
    r_cyc = cyc;
    check("mask_redirect", 64'(redirect_valid), 64'd1);
    @(negedge clk);
    csr_ack = 1;
    @(negedge clk);
    csr_ack = 0;
    seen = 0;
    tv_cyc = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (trap_valid) begin
        seen = 1;
        tv_cyc = cyc;
      end
    end
    check("mask_second_seen", 64'(seen), 64'd1);
    check("mask_gap", 64'(tv_cyc - r_cyc), 64'd3);

    // Reset while the offer is pending
    exc_req = '0;
    @(negedge clk);
    check("offer_pending", 64'(trap_valid), 64'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst_mid_outputs", 64'({trap_valid, trap_is_irq, flush, redirect_valid, busy}), 64'd0);
    check("rst_mid_record", 64'({trap_cause, trap_pc}), 64'd0);
    repeat (4) @(negedge clk);
    check("rst_mid_no_redirect", 64'({redirect_valid, busy}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
